// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : In-order instruction-fetch queue between the PC register and ID.
//            Issues PC-tagged fetches, fills slots from in-order memory
//            responses, and discards in-flight fetches on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_wr_en,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0]   C_DEPTH = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] C_ONE   = PW'(1);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_drop;
    logic [31:0]   r_slot_pc   [DEPTH];
    logic [31:0]   r_slot_inst [DEPTH];

    logic [PW-1:0] w_count;
    logic [PW-1:0] w_outst;
    logic [PW:0]   w_occupied;
    logic          w_credit;
    logic          w_fire;
    logic          w_pop;
    logic          w_rsp_drop;
    logic          w_rsp_fill;
    logic [PW-1:0] w_flush_dec;
    logic [PW-1:0] w_drop_flush;

    assign w_count    = r_tail - r_head;
    assign w_outst    = r_tail - r_fill;
    // Dropped responses still occupy credit: they will arrive regardless.
    assign w_occupied = {1'b0, w_count} + {1'b0, r_drop};
    assign w_credit   = (w_occupied < C_DEPTH);

    assign imem_req_valid = w_credit & ~flush & ~rst;
    assign imem_req_addr  = pc_in;
    assign w_fire         = imem_req_valid & imem_req_ready;
    assign pc_wr_en       = w_fire | flush;

    assign id_valid = (r_head != r_fill) & ~flush;
    assign id_inst  = r_slot_inst[r_head[AW-1:0]];
    assign id_pc    = r_slot_pc[r_head[AW-1:0]];
    assign w_pop    = id_valid & id_ready;

    assign w_rsp_drop = imem_rsp_valid & (r_drop != '0);
    assign w_rsp_fill = imem_rsp_valid & (r_drop == '0) & (r_fill != r_tail) & ~flush;

    // A response landing in the flush cycle retires one stale fetch immediately;
    // an unsolicited one (nothing pending) must not underflow the counter.
    assign w_flush_dec  = (imem_rsp_valid && ((r_drop != '0) || (w_outst != '0))) ? C_ONE : '0;
    assign w_drop_flush = r_drop + w_outst - w_flush_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_fill <= '0;
            r_tail <= '0;
            r_drop <= '0;
        end else if (flush) begin
            r_head <= r_tail;
            r_fill <= r_tail;
            r_drop <= w_drop_flush;
        end else begin
            if (w_fire) begin
                r_tail <= r_tail + C_ONE;
            end
            if (w_rsp_fill) begin
                r_fill <= r_fill + C_ONE;
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - C_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_pc[i]   <= '0;
                r_slot_inst[i] <= '0;
            end
        end else begin
            if (w_fire) begin
                r_slot_pc[r_tail[AW-1:0]] <= pc_in;
            end
            if (w_rsp_fill) begin
                r_slot_inst[r_fill[AW-1:0]] <= imem_rsp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Directed testbench for if_fetch_queue with a PC register and a
//            fixed-latency in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_wr_en;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_wr_en       (pc_wr_en),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    localparam logic [31:0] C_XOR = 32'hA5A5_0000;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] pc       = 32'h0;
    logic [31:0] flush_target = 32'h0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_pc_wr_en;
    logic        s_id_valid;
    logic [31:0] s_id_pc;
    logic [31:0] s_id_inst;
    logic        rsp_now;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, sample outputs mid-cycle, then advance the models.
    task automatic cycle();
        rsp_now        = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? (mq_addr[0] ^ C_XOR) : 32'hDEAD_BEEF;
        pc_in          = pc;
        #3;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_pc_wr_en  = pc_wr_en;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_inst   = id_inst;
        @(posedge clk);
        #1;
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            pc = 32'h0;
        end else begin
            if (rsp_now) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (s_req_valid && imem_req_ready) begin
                mq_addr.push_back(s_req_addr);
                mq_due.push_back(cyc + lat);
            end
            if (s_pc_wr_en) pc = flush ? flush_target : pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b0 || s_id_pc !== 32'h0 || s_id_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_id: got valid=%b pc=%h inst=%h, want 0/0/0", s_id_valid, s_id_pc, s_id_inst);
        end
        n_checks++;
        if (s_req_valid !== 1'b0 || s_pc_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got req_valid=%b pc_wr_en=%b, want 0/0", s_req_valid, s_pc_wr_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc;
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (s_req_valid !== 1'b1 || s_pc_wr_en !== 1'b1 || s_req_addr !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL basic_req c%0d: got valid=%b wr=%b addr=%h, want 1/1/%h",
                         i, s_req_valid, s_pc_wr_en, s_req_addr, 32'(4 * i));
            end
            n_checks++;
            if (i < 2) begin
                if (s_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_id_early c%0d: got id_valid=%b, want 0", i, s_id_valid);
                end
            end else begin
                exp_pc = 32'(4 * (i - 2));
                if (s_id_valid !== 1'b1 || s_id_pc !== exp_pc || s_id_inst !== (exp_pc ^ C_XOR)) begin
                    n_fail++;
                    $display("FAIL basic_id c%0d: got valid=%b pc=%h inst=%h, want 1 pc=%h inst=%h",
                             i, s_id_valid, s_id_pc, s_id_inst, exp_pc, exp_pc ^ C_XOR);
                end
            end
        end
    endtask

    task automatic test_full();
        int fires;
        logic [31:0] exp_pc;
        do_reset();
        lat = 1;
        id_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_req_valid && imem_req_ready) fires++;
        end
        n_checks++;
        if (fires != 4) begin
            n_fail++;
            $display("FAIL full_fires: got %0d fires, want 4", fires);
        end
        n_checks++;
        if (s_req_valid !== 1'b0 || s_pc_wr_en !== 1'b0 || s_req_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL full_hold: got req_valid=%b wr=%b addr=%h, want 0/0/00000010",
                     s_req_valid, s_pc_wr_en, s_req_addr);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            exp_pc = 32'(4 * k);
            n_checks++;
            if (s_id_valid !== 1'b1 || s_id_pc !== exp_pc || s_id_inst !== (exp_pc ^ C_XOR)) begin
                n_fail++;
                $display("FAIL full_drain d%0d: got valid=%b pc=%h inst=%h, want 1 pc=%h inst=%h",
                         k, s_id_valid, s_id_pc, s_id_inst, exp_pc, exp_pc ^ C_XOR);
            end
            if (k == 0) begin
                n_checks++;
                if (s_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_pop_cycle: got req_valid=%b, want 0", s_req_valid);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (s_req_valid !== 1'b1 || s_pc_wr_en !== 1'b1 || s_req_addr !== 32'h10) begin
                    n_fail++;
                    $display("FAIL full_resume: got valid=%b wr=%b addr=%h, want 1/1/00000010",
                             s_req_valid, s_pc_wr_en, s_req_addr);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1;
        for (int i = 0; i < 3; i++) cycle();
        imem_req_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            n_checks++;
            if (s_pc_wr_en !== 1'b0 || s_req_addr !== 32'hC) begin
                n_fail++;
                $display("FAIL stall_hold s%0d: got wr=%b addr=%h, want 0/0000000c", s, s_pc_wr_en, s_req_addr);
            end
        end
        n_checks++;
        if (s_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_noalloc: got id_valid=%b, want 0", s_id_valid);
        end
        imem_req_ready = 1'b1;
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_pc_wr_en !== 1'b1 || s_req_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_resume: got valid=%b wr=%b addr=%h, want 1/1/0000000c",
                     s_req_valid, s_pc_wr_en, s_req_addr);
        end
        cycle();
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'hC || s_id_inst !== (32'hC ^ C_XOR)) begin
            n_fail++;
            $display("FAIL stall_id: got valid=%b pc=%h inst=%h, want 1 pc=0000000c inst=%h",
                     s_id_valid, s_id_pc, s_id_inst, 32'hC ^ C_XOR);
        end
    endtask

    task automatic test_flush();
        do_reset();
        lat = 3;
        id_ready = 1'b0;
        flush_target = 32'h100;
        cycle();
        imem_req_ready = 1'b0;
        cycle();
        cycle();
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        // Now: one buffered (0x0), two outstanding (0x4, 0x8).
        flush = 1'b1;
        id_ready = 1'b1;
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b0 || s_pc_wr_en !== 1'b1 || s_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got req_valid=%b wr=%b id_valid=%b, want 0/1/0",
                     s_req_valid, s_pc_wr_en, s_id_valid);
        end
        flush = 1'b0;
        for (int k = 6; k < 10; k++) begin
            cycle();
            n_checks++;
            if (s_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale c%0d: got id_valid=%b pc=%h, want id_valid=0", k, s_id_valid, s_id_pc);
            end
            if (k == 6) begin
                n_checks++;
                if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
                    n_fail++;
                    $display("FAIL flush_refetch: got valid=%b addr=%h, want 1/00000100", s_req_valid, s_req_addr);
                end
            end
        end
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h100 || s_id_inst !== (32'h100 ^ C_XOR)) begin
            n_fail++;
            $display("FAIL flush_first: got valid=%b pc=%h inst=%h, want 1 pc=00000100 inst=%h",
                     s_id_valid, s_id_pc, s_id_inst, 32'h100 ^ C_XOR);
        end
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h104 || s_id_inst !== (32'h104 ^ C_XOR)) begin
            n_fail++;
            $display("FAIL flush_second: got valid=%b pc=%h inst=%h, want 1 pc=00000104 inst=%h",
                     s_id_valid, s_id_pc, s_id_inst, 32'h104 ^ C_XOR);
        end
    endtask

    task automatic test_flush_rsp();
        do_reset();
        lat = 3;
        flush_target = 32'h200;
        for (int i = 0; i < 4; i++) cycle();
        // Response for 0x4 arrives in the flush cycle; 0x8 and 0xC remain in flight.
        flush = 1'b1;
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b0 || s_req_valid !== 1'b0 || s_pc_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL flushrsp_cycle: got id_valid=%b req_valid=%b wr=%b, want 0/0/1",
                     s_id_valid, s_req_valid, s_pc_wr_en);
        end
        flush = 1'b0;
        for (int k = 5; k < 9; k++) begin
            cycle();
            n_checks++;
            if (s_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flushrsp_empty c%0d: got id_valid=%b pc=%h, want id_valid=0", k, s_id_valid, s_id_pc);
            end
            if (k == 5) begin
                n_checks++;
                if (s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin
                    n_fail++;
                    $display("FAIL flushrsp_refetch: got valid=%b addr=%h, want 1/00000200", s_req_valid, s_req_addr);
                end
            end
        end
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h200 || s_id_inst !== (32'h200 ^ C_XOR)) begin
            n_fail++;
            $display("FAIL flushrsp_first: got valid=%b pc=%h inst=%h, want 1 pc=00000200 inst=%h",
                     s_id_valid, s_id_pc, s_id_inst, 32'h200 ^ C_XOR);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        lat = 1;
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b0 || s_pc_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_req: got req_valid=%b wr=%b, want 0/0", s_req_valid, s_pc_wr_en);
        end
        rst = 1'b0;
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b0 || s_id_pc !== 32'h0 || s_id_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: got valid=%b pc=%h inst=%h, want 0/0/0", s_id_valid, s_id_pc, s_id_inst);
        end
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_refetch: got valid=%b addr=%h, want 1/00000000", s_req_valid, s_req_addr);
        end
        cycle();
        cycle();
        n_checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0 || s_id_inst !== C_XOR) begin
            n_fail++;
            $display("FAIL rstmid_first: got valid=%b pc=%h inst=%h, want 1 pc=00000000 inst=%h",
                     s_id_valid, s_id_pc, s_id_inst, C_XOR);
        end
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        pc_in          = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_flush();
        test_flush_rsp();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
